// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between operand fetch (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int N = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   mode;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [N-1:0] out_hi;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_neg;
  logic         flag_ovf;

  modport master (
    output in_valid, mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, out_hi,
           flag_zero, flag_carry, flag_neg, flag_ovf
  );

  modport slave (
    input  in_valid, mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out, out_hi,
           flag_zero, flag_carry, flag_neg, flag_ovf
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned N-cycle shift-add multiplier; done/prod show the final step's result
// combinationally so the caller can register it on the same edge.
module alu_mul_iter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;
  logic           busy;
  logic [N:0]     sum;
  logic [2*N-1:0] acc_step;

  // Low half starts as the multiplier and is consumed one bit per step
  // while the partial product grows into the high half.
  always_comb begin
    sum      = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? mcand : {N{1'b0}})};
    acc_step = {sum, acc[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{N{1'b0}}, b};
      count <= CW'(N);
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc_step;
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (count == CW'(1));
  assign prod = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an iterative multiply,
// with registered result and flags held until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(N);

  state_t         state;
  state_t         state_next;
  op_t            op;
  logic           in_ready;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] mul_prod;

  logic [N-1:0]   res;
  logic           res_carry;
  logic           res_ovf;
  logic [N:0]     add_full;
  logic [N:0]     sub_full;
  logic [N:0]     shl_full;
  logic [N:0]     shr_full;
  logic [SHW-1:0] shamt;

  logic [N-1:0]   out_q;
  logic [N-1:0]   out_hi_q;
  logic           zero_q;
  logic           carry_q;
  logic           neg_q;
  logic           ovf_q;

  assign op        = op_t'(bus.mode);
  assign accept    = bus.in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE may accept the next request on the edge its result is consumed.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = (op == OP_MUL) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_next = (op == OP_MUL) ? BUSY : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    shamt     = bus.in_b[SHW-1:0];
    add_full  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    sub_full  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    shl_full  = {1'b0, bus.in_a} << shamt;
    shr_full  = {bus.in_a, 1'b0} >> shamt;
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        res       = add_full[N-1:0];
        res_carry = add_full[N];
        res_ovf   = (bus.in_a[N-1] == bus.in_b[N-1]) && (add_full[N-1] != bus.in_a[N-1]);
      end
      OP_SUB: begin
        res       = sub_full[N-1:0];
        res_carry = sub_full[N];
        res_ovf   = (bus.in_a[N-1] != bus.in_b[N-1]) && (sub_full[N-1] != bus.in_a[N-1]);
      end
      OP_AND: res = bus.in_a & bus.in_b;
      OP_OR:  res = bus.in_a | bus.in_b;
      OP_XOR: res = bus.in_a ^ bus.in_b;
      OP_SHL: begin
        res       = shl_full[N-1:0];
        res_carry = shl_full[N];
      end
      OP_SHR: begin
        res       = shr_full[N:1];
        res_carry = shr_full[0];
      end
      default: begin
        res = '0;
      end
    endcase
  end

  alu_mul_iter #(
    .N(N)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.in_a),
    .b     (bus.in_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Result and flags change only when a new result is loaded on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept && (op != OP_MUL)) begin
      out_q    <= res;
      out_hi_q <= '0;
      zero_q   <= (res == '0);
      carry_q  <= res_carry;
      neg_q    <= res[N-1];
      ovf_q    <= res_ovf;
    end else if (state == BUSY && mul_done) begin
      out_q    <= mul_prod[N-1:0];
      out_hi_q <= mul_prod[2*N-1:N];
      zero_q   <= (mul_prod[N-1:0] == '0);
      carry_q  <= |mul_prod[2*N-1:N];
      neg_q    <= mul_prod[N-1];
      ovf_q    <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state == DONE);
  assign bus.out        = out_q;
  assign bus.out_hi     = out_hi_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_neg   = neg_q;
  assign bus.flag_ovf   = ovf_q;

endmodule
